axis_egress_stats_monitor: RTL
==============================

Name: axis_egress_stats_monitor

Overview:
- Downstream stage of the queue manager's egress AXI-Stream.
- Forwards the stream through a full-throughput skid buffer.
- Validates framing, and keeps per-ingress-port packet, byte and error counters keyed on tuser.port_id.
- Software or the bench reads the counters through a simple registered read port.

Parameters:
- DATA_SIZE, 32, tdata width in bits; tkeep width is DATA_SIZE/8.
- NUM_OF_INGRESS_PORTS, 3, number of valid port_id values (0..N-1).
- PORT_ID_WIDTH, 2, port_id field width in tuser.
- VLAN_ID_WIDTH, 12, vlan_id field width in tuser.
- CNT_WIDTH, 32, width of every statistics counter.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous active-high reset.
- s_axis_tvalid, input, 1, upstream beat valid.
- s_axis_tready, output, 1, upstream beat accepted.
- s_axis_tdata, input, DATA_SIZE, beat data.
- s_axis_tkeep, input, DATA_SIZE/8, byte enables.
- s_axis_tlast, input, 1, end of packet.
- s_axis_tuser, input, PORT_ID_WIDTH+VLAN_ID_WIDTH, {port_id, vlan_id}; port_id is in the MSBs.
- m_axis_tvalid/tready/tdata/tkeep/tlast/tuser, output/input/output/output/output/output, same widths as the s_axis_* signals, forwarded stream.
- stat_rd_en, input, 1, counter read strobe.
- stat_rd_port, input, PORT_ID_WIDTH, port to read.
- stat_rd_sel, input, 2, counter select: 0 = pkt, 1 = byte, 2 = err, 3 = drop.
- stat_rd_data, output, CNT_WIDTH, read data.
- stat_rd_valid, output, 1, read data valid.
- stat_clr, input, 1, clear all counters.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- Reset values:
  - m_axis_tvalid=0, s_axis_tready=0 while rst=1; s_axis_tready=1 the first cycle after rst deasserts.
  - m_axis_tdata/tkeep/tlast/tuser=0.
  - stat_rd_data=0, stat_rd_valid=0.
  - All counters 0, FSM in IDLE.
  - Reset mid-packet discards skid contents; the partial packet is not counted.
- Skid buffer:
  - Two entries, registered outputs; latency 1 cycle from s handshake to m_axis_tvalid.
  - Sustains 1 beat/cycle with m_axis_tready held high.
  - s_axis_tready is registered and deasserts only when both entries are occupied.
  - m_axis_* are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Beat evaluation is performed on the output handshake (m_axis_tvalid && m_axis_tready).
- FSM states and transitions:
  - IDLE, beat with tlast=0 -> IN_PKT; latch tuser, set pkt_len = popcount(tkeep).
  - IDLE, beat with tlast=1 -> single-beat packet, commit, remain in IDLE.
  - IN_PKT, beat -> pkt_len += popcount(tkeep); on tlast, commit and go to IDLE.
- Error conditions, each marking the packet errored:
  - tuser differs from the latched value on any non-first beat.
  - Non-last beat whose tkeep is not all ones.
  - Last beat whose tkeep is zero or not contiguous from bit 0.
  - port_id >= NUM_OF_INGRESS_PORTS.
- Commit on the tlast beat:
  - Valid port, no error: pkt_cnt[port]++ and byte_cnt[port] += pkt_len.
  - Valid port, errored: err_cnt[port]++ only.
  - Invalid port_id: the packet is forwarded but counted nowhere.
- Counters saturate at all ones; they never wrap.
- Read port:
  - stat_rd_en samples the counter; stat_rd_data and stat_rd_valid appear the next cycle; stat_rd_valid is a 1-cycle pulse.
  - A read in the same cycle as an increment returns the pre-increment value.
  - stat_rd_port out of range returns 0.
- stat_clr zeroes all counters the next cycle; clear beats a same-cycle increment. Clear does not affect the FSM or stream.
- Stream data is never modified.

Optional Feature:
- Macro: AXIS_EGRESS_VLAN_DROP_EN.
- Defined:
  - A packet whose first-beat vlan_id is all ones (0xFFF) is dropped.
  - Its beats are accepted upstream at full rate but m_axis_tvalid stays 0 for them.
  - drop_cnt[port]++ at tlast; pkt_cnt and byte_cnt are not incremented.
  - The drop decision is evaluated on the skid-buffer input side so no bubble is emitted downstream.
- Undefined:
  - All packets are forwarded.
  - drop_cnt is not implemented; sel=3 reads 0.

Decomposition:
- Package axis_qm_pkg:
  - connection_addr_t struct {port_id, vlan_id}.
  - Default width constants: port_id, vlan_id, NUM_OF_INGRESS_PORTS.
  - stat_sel_e enum: PKT, BYTE, ERR, DROP.
  - VLAN_RESERVED = 12'hFFF.
- Sub-module axis_skid_buffer:
  - Parameterised on total payload width (tdata+tkeep+tlast+tuser).
  - Same clk/rst convention.

Test Plan:
- Clean traffic: 3 packets of 4 beats, tkeep=4'hF except last beat 4'h3, port_id 0/1/2, m_axis_tready=1 -> output identical with 1-cycle latency; per port pkt=1, byte=14, err=0.
- Backpressure: m_axis_tready toggled 1-0-1-0 over a 10-beat packet -> no beat lost or duplicated; s_axis_tready low only when skid is full; byte=40.
- Framing error: tuser port changes mid-packet on port 1, plus a middle beat with tkeep=4'h7 on port 2 -> err_cnt[1]=1 and err_cnt[2]=1; pkt_cnt unchanged; data still forwarded.
- Saturation: preload via force or use CNT_WIDTH=4, send 20 packets on port 0 -> pkt_cnt holds 15.
- Read and clear race: stat_rd_en and stat_clr in the same cycle as a port-0 tlast commit -> read returns the old value; the next read returns 0.
- Macro defined: vlan_id=0xFFF packet on port 2 -> no m_axis_tvalid for it; drop_cnt[2]=1; pkt_cnt[2]=0; a following normal packet forwards back-to-back.

Source files
------------

// File: rtl/axis_qm_pkg.sv
// axis_qm_pkg: shared types and default widths for the queue-manager egress stream.
package axis_qm_pkg;
    localparam int PORT_ID_W = 2;
    localparam int VLAN_ID_W = 12;
    localparam int DEF_NUM_PORTS = 3;
    localparam logic [VLAN_ID_W-1:0] VLAN_RESERVED = 12'hFFF;
    typedef struct packed {
        logic [PORT_ID_W-1:0] port_id;
        logic [VLAN_ID_W-1:0] vlan_id;
    } connection_addr_t;
    typedef enum logic [1:0] {PKT, BYTE, ERR, DROP} stat_sel_e;
    typedef enum logic {IDLE, IN_PKT} mon_state_e;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry skid buffer, registered valid/data/ready, full throughput.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid, r_skid_valid, r_ready;
    logic [WIDTH-1:0] r_data, r_skid_data;
    logic             w_in, w_out_ready, w_skid_nxt;
    assign w_in        = i_valid && r_ready;
    assign w_out_ready = i_ready || !r_valid;
    // ready is registered, so the skid entry absorbs the one beat in flight on a stall
    assign w_skid_nxt  = !w_out_ready && (r_skid_valid || w_in);
    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
            r_data       <= '0;
            r_skid_data  <= '0;
        end else begin
            r_ready      <= !w_skid_nxt;
            r_skid_valid <= w_skid_nxt;
            if (w_out_ready) begin
                r_valid <= r_skid_valid || w_in;
                if (r_skid_valid) r_data <= r_skid_data;
                else if (w_in) r_data <= i_data;
            end else if (w_in) begin
                r_skid_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/axis_egress_stats_monitor.sv
// axis_egress_stats_monitor: forwards egress AXI-Stream, checks framing, keeps per-port counters.
// Optional AXIS_EGRESS_VLAN_DROP_EN drops packets whose first-beat vlan_id is reserved.
module axis_egress_stats_monitor import axis_qm_pkg::*; #(
    parameter int DATA_SIZE            = 32,
    parameter int NUM_OF_INGRESS_PORTS = DEF_NUM_PORTS,
    parameter int PORT_ID_WIDTH        = PORT_ID_W,
    parameter int VLAN_ID_WIDTH        = VLAN_ID_W,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic [DATA_SIZE-1:0]                   s_axis_tdata,
    input  logic [DATA_SIZE/8-1:0]                 s_axis_tkeep,
    input  logic                                   s_axis_tlast,
    input  logic [PORT_ID_WIDTH+VLAN_ID_WIDTH-1:0] s_axis_tuser,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [DATA_SIZE-1:0]                   m_axis_tdata,
    output logic [DATA_SIZE/8-1:0]                 m_axis_tkeep,
    output logic                                   m_axis_tlast,
    output logic [PORT_ID_WIDTH+VLAN_ID_WIDTH-1:0] m_axis_tuser,
    input  logic                                   stat_rd_en,
    input  logic [PORT_ID_WIDTH-1:0]               stat_rd_port,
    input  logic [1:0]                             stat_rd_sel,
    output logic [CNT_WIDTH-1:0]                   stat_rd_data,
    output logic                                   stat_rd_valid,
    input  logic                                   stat_clr
);
    localparam int KW = DATA_SIZE / 8;
    localparam int UW = PORT_ID_WIDTH + VLAN_ID_WIDTH;
    localparam int PW = UW + 1 + KW + DATA_SIZE;
    localparam logic [PORT_ID_WIDTH:0] NP = (PORT_ID_WIDTH + 1)'(NUM_OF_INGRESS_PORTS);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    logic                 w_skid_in_valid;
    logic [PW-1:0]        w_m_payload;
    logic [CNT_WIDTH-1:0] w_drop [NUM_OF_INGRESS_PORTS];

`ifdef AXIS_EGRESS_VLAN_DROP_EN
    logic                 r_in_mid, r_in_drop;
    logic [PORT_ID_WIDTH-1:0] r_in_port, w_in_port;
    logic                 w_in_hs, w_drop_beat, w_drop_commit;
    logic [CNT_WIDTH-1:0] r_drop [NUM_OF_INGRESS_PORTS];
    // drop decision on the input side keeps dropped beats out of the skid entirely
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_drop_beat   = r_in_mid ? r_in_drop : s_axis_tuser[VLAN_ID_WIDTH-1:0] == VLAN_ID_WIDTH'(VLAN_RESERVED);
    assign w_in_port     = r_in_mid ? r_in_port : s_axis_tuser[UW-1 -: PORT_ID_WIDTH];
    assign w_drop_commit = w_in_hs && s_axis_tlast && w_drop_beat && ({1'b0, w_in_port} < NP);
    assign w_skid_in_valid = s_axis_tvalid && !w_drop_beat;
    assign w_drop        = r_drop;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_mid  <= 1'b0;
            r_in_drop <= 1'b0;
            r_in_port <= '0;
        end else if (w_in_hs) begin
            r_in_mid  <= !s_axis_tlast;
            r_in_drop <= w_drop_beat;
            r_in_port <= w_in_port;
        end
        for (int i = 0; i < NUM_OF_INGRESS_PORTS; i++)
            if (rst || stat_clr) r_drop[i] <= '0;
            else if (w_drop_commit && w_in_port == PORT_ID_WIDTH'(i)) r_drop[i] <= sat_add(r_drop[i], CNT_WIDTH'(1));
    end
`else
    assign w_skid_in_valid = s_axis_tvalid;
    assign w_drop          = '{default: '0};
`endif

    axis_skid_buffer #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_skid_in_valid),
        .o_ready (s_axis_tready),
        .i_data  ({s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_m_payload)
    );
    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = w_m_payload;

    mon_state_e               r_state, w_state_nxt;
    logic [UW-1:0]            r_user;
    logic [CNT_WIDTH-1:0]     r_len, w_len;
    logic                     r_err, w_err, w_beat, w_first, w_commit, w_port_ok, w_contig;
    logic [PORT_ID_WIDTH-1:0] w_port;
    always_comb begin
        w_beat      = m_axis_tvalid && m_axis_tready;
        w_first     = r_state == IDLE;
        w_port      = w_first ? m_axis_tuser[UW-1 -: PORT_ID_WIDTH] : r_user[UW-1 -: PORT_ID_WIDTH];
        w_port_ok   = {1'b0, w_port} < NP;
        w_contig    = |m_axis_tkeep && ((m_axis_tkeep & (m_axis_tkeep + KW'(1))) == '0);
        w_len       = sat_add(w_first ? '0 : r_len, CNT_WIDTH'($countones(m_axis_tkeep)));
        w_err       = (!w_first && (r_err || m_axis_tuser != r_user)) || !w_port_ok ||
                      (m_axis_tlast ? !w_contig : !(&m_axis_tkeep));
        w_commit    = w_beat && m_axis_tlast && w_port_ok;
        w_state_nxt = !w_beat ? r_state : m_axis_tlast ? IDLE : IN_PKT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_user  <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat && w_first) r_user <= m_axis_tuser;
            if (w_beat) begin
                r_len <= w_len;
                r_err <= w_err;
            end
        end
    end

    logic [CNT_WIDTH-1:0] r_pkt [NUM_OF_INGRESS_PORTS];
    logic [CNT_WIDTH-1:0] r_byte [NUM_OF_INGRESS_PORTS];
    logic [CNT_WIDTH-1:0] r_errc [NUM_OF_INGRESS_PORTS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OF_INGRESS_PORTS; i++) begin
            if (rst || stat_clr) begin
                r_pkt[i]  <= '0;
                r_byte[i] <= '0;
                r_errc[i] <= '0;
            end else if (w_commit && w_port == PORT_ID_WIDTH'(i)) begin
                if (w_err) r_errc[i] <= sat_add(r_errc[i], CNT_WIDTH'(1));
                else begin
                    r_pkt[i]  <= sat_add(r_pkt[i], CNT_WIDTH'(1));
                    r_byte[i] <= sat_add(r_byte[i], w_len);
                end
            end
        end
    end

    stat_sel_e            w_sel;
    logic [CNT_WIDTH-1:0] w_rd_mux, r_rd_data;
    logic                 r_rd_valid;
    always_comb begin
        w_sel    = stat_sel_e'(stat_rd_sel);
        w_rd_mux = '0;
        for (int i = 0; i < NUM_OF_INGRESS_PORTS; i++)
            if (stat_rd_port == PORT_ID_WIDTH'(i))
                w_rd_mux = w_sel == PKT ? r_pkt[i] : w_sel == BYTE ? r_byte[i] : w_sel == ERR ? r_errc[i] : w_drop[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= stat_rd_en;
            if (stat_rd_en) r_rd_data <= w_rd_mux;
        end
    end
    assign stat_rd_data  = r_rd_data;
    assign stat_rd_valid = r_rd_valid;
endmodule
